elevator_controller: RTL and testbench

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

---
 rtl/elevator_controller.sv | 172 +++++++++++++++++
 tb/tb_elevator_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// ---------------------------------------------------------------------------
// elevator_controller
//
// Single-cabin elevator controller. Floor calls are latched into a pending
// vector. The cabin picks its travel direction only while idle: it keeps the
// current direction while calls remain ahead of it, and reverses otherwise.
// While travelling, it stops at every called floor it reaches.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req        in   [FLOORS-1:0] floor call buttons, sampled every edge
//   floor      out  [W-1:0] current floor index
//   moving     out  cabin travelling between floors
//   up_down    out  travel direction (1 = up, 0 = down); held while stopped
//   door_open  out  door open at the current floor
//   pending    out  [FLOORS-1:0] registered calls not yet served
// ---------------------------------------------------------------------------
module elevator_controller #(
  parameter int FLOORS        = 10,
  parameter int W             = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] req,
  output logic [W-1:0]      floor,
  output logic              moving,
  output logic              up_down,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);

  localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_DOOR_OPEN
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      floor_q, floor_d;
  logic              up_down_q, up_down_d;
  logic              moving_q, moving_d;
  logic              door_open_q, door_open_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [CW-1:0]     travel_cnt_q, travel_cnt_d;
  logic [CW-1:0]     dwell_cnt_q, dwell_cnt_d;

  logic [FLOORS-1:0] calls;
  logic [W-1:0]      step_floor;
  logic              can_step;

  // True when any bit of vec lies strictly above (up=1) or below (up=0) f.
  function automatic logic any_beyond(input logic [FLOORS-1:0] vec,
                                      input logic [W-1:0]      f,
                                      input logic              up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (vec[i] && (up ? (W'(i) > f) : (W'(i) < f))) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal assigned below gets a default here first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d      = state_q;
    floor_d      = floor_q;
    up_down_d    = up_down_q;
    travel_cnt_d = travel_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;

    // Calls visible this edge: already latched ones plus fresh button presses.
    calls      = pending_q | req;
    pending_d  = calls;
    step_floor = up_down_q ? (floor_q + W'(1)) : (floor_q - W'(1));
    can_step   = up_down_q ? (floor_q != W'(FLOORS - 1)) : (floor_q != '0);

    unique case (state_q)
      S_IDLE: begin
        if (calls[floor_q]) begin
          // Call at the current floor is served on the spot.
          state_d            = S_DOOR_OPEN;
          dwell_cnt_d        = CW'(DOOR_CYCLES);
          pending_d[floor_q] = 1'b0;
        end else if (|pending_q) begin
          state_d      = S_MOVING;
          travel_cnt_d = CW'(TRAVEL_CYCLES);
          if (!any_beyond(pending_q, floor_q, up_down_q)) up_down_d = ~up_down_q;
        end
      end

      S_MOVING: begin
        if (travel_cnt_q == CW'(1)) begin
          if (!can_step) begin
            // End of the shaft: never wrap, let IDLE re-plan.
            state_d      = S_IDLE;
            travel_cnt_d = '0;
          end else begin
            floor_d      = step_floor;
            travel_cnt_d = CW'(TRAVEL_CYCLES);
            if (calls[step_floor]) begin
              state_d               = S_DOOR_OPEN;
              dwell_cnt_d           = CW'(DOOR_CYCLES);
              travel_cnt_d          = '0;
              pending_d[step_floor] = 1'b0;
            end else if (!any_beyond(calls, step_floor, up_down_q)) begin
              state_d      = S_IDLE;
              travel_cnt_d = '0;
            end
          end
        end else begin
          travel_cnt_d = travel_cnt_q - CW'(1);
        end
      end

      S_DOOR_OPEN: begin
        // Presses at the open floor never become pending; they hold the door.
        pending_d[floor_q] = 1'b0;
        if (req[floor_q]) begin
          dwell_cnt_d = CW'(DOOR_CYCLES);
        end else if (dwell_cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          dwell_cnt_d = '0;
        end else begin
          dwell_cnt_d = dwell_cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    moving_d    = (state_d == S_MOVING);
    door_open_d = (state_d == S_DOOR_OPEN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      floor_q      <= '0;
      up_down_q    <= 1'b1;
      moving_q     <= 1'b0;
      door_open_q  <= 1'b0;
      pending_q    <= '0;
      travel_cnt_q <= '0;
      dwell_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      up_down_q    <= up_down_d;
      moving_q     <= moving_d;
      door_open_q  <= door_open_d;
      pending_q    <= pending_d;
      travel_cnt_q <= travel_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
    end
  end

  assign floor     = floor_q;
  assign moving    = moving_q;
  assign up_down   = up_down_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// ---------------------------------------------------------------------------
// tb_elevator_controller
//
// Scoreboard bench. Each directed scenario pushes the expected sequence of
// output changes (new output snapshot plus the number of cycles since the
// previous change) into a queue. Monitors watch the DUT outputs on the falling
// clock edge and pop/compare whenever the outputs change. Two instances are
// used: the default 10-floor build and a 16-floor build.
// ---------------------------------------------------------------------------
module tb_elevator_controller;

  typedef struct packed {
    logic [3:0]  floor;
    logic        moving;
    logic        door;
    logic        up;
    logic [15:0] pend;
  } snap_t;

  typedef struct {
    int    gap;
    snap_t s;
  } exp_t;

  localparam snap_t RST_SNAP = '{floor: 4'd0, moving: 1'b0, door: 1'b0, up: 1'b1, pend: 16'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  req10 = '0;
  logic [15:0] req16 = '0;

  logic [3:0]  floor10, floor16;
  logic        moving10, moving16, up10, up16, door10, door16;
  logic [9:0]  pend10;
  logic [15:0] pend16;

  int checks = 0;
  int errors = 0;

  exp_t  q0[$];
  exp_t  q1[$];
  snap_t s0, s1, prev0, prev1;
  int    cyc0 = 0;
  int    cyc1 = 0;

  always #5 clk = ~clk;

  elevator_controller #(.FLOORS(10), .W(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) u10 (
    .clk       (clk),
    .reset     (reset),
    .req       (req10),
    .floor     (floor10),
    .moving    (moving10),
    .up_down   (up10),
    .door_open (door10),
    .pending   (pend10)
  );

  elevator_controller #(.FLOORS(16), .W(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) u16 (
    .clk       (clk),
    .reset     (reset),
    .req       (req16),
    .floor     (floor16),
    .moving    (moving16),
    .up_down   (up16),
    .door_open (door16),
    .pending   (pend16)
  );

  assign s0 = {floor10, moving10, door10, up10, 6'd0, pend10};
  assign s1 = {floor16, moving16, door16, up16, pend16};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic snap_t mk(input int f, input bit mv, input bit dr, input bit up, input int p);
    snap_t s;
    s.floor  = 4'(f);
    s.moving = mv;
    s.door   = dr;
    s.up     = up;
    s.pend   = 16'(p);
    return s;
  endfunction

  task automatic e10(input int gap, input int f, input bit mv, input bit dr, input bit up, input int p);
    exp_t e;
    e.gap = gap;
    e.s   = mk(f, mv, dr, up, p);
    q0.push_back(e);
  endtask

  task automatic e16(input int gap, input int f, input bit mv, input bit dr, input bit up, input int p);
    exp_t e;
    e.gap = gap;
    e.s   = mk(f, mv, dr, up, p);
    q1.push_back(e);
  endtask

  // Pops the next expected change for instance id and compares it.
  task automatic on_change(input int id, input snap_t s, input int cyc);
    exp_t e;
    if ((id == 0 ? q0.size() : q1.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d unexpected change actual=%h expected=none (t=%0t)",
               id == 0 ? 10 : 16, s, $time);
    end else begin
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      check(id == 0 ? "u10 outputs" : "u16 outputs", 32'(s), 32'(e.s));
      check(id == 0 ? "u10 gap" : "u16 gap", cyc, e.gap);
    end
  endtask

  // Monitors: reset restarts the cycle count and re-baselines the snapshot.
  always @(negedge clk) begin
    if (!reset) begin
      prev0 = s0;
      cyc0  = 0;
    end else begin
      cyc0++;
      if (s0 !== prev0) begin
        on_change(0, s0, cyc0);
        prev0 = s0;
        cyc0  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev1 = s1;
      cyc1  = 0;
    end else begin
      cyc1++;
      if (s1 !== prev1) begin
        on_change(1, s1, cyc1);
        prev1 = s1;
        cyc1  = 0;
      end
    end
  end

  // Reset must take effect without waiting for a clock edge.
  always @(negedge reset) begin
    #1;
    check("u10 async reset", 32'(s0), 32'(RST_SNAP));
    check("u16 async reset", 32'(s1), 32'(RST_SNAP));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse10(input logic [9:0] m);
    req10 = m;
    step(1);
    req10 = '0;
  endtask

  task automatic pulse16(input logic [15:0] m);
    req16 = m;
    step(1);
    req16 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    #2;
    reset = 1'b0;
    step(2);
    reset = 1'b1;

    // Single call to floor 2 from floor 0.
    e10(1, 0, 0, 0, 1, 'h004);
    e10(1, 0, 1, 0, 1, 'h004);
    e10(4, 1, 1, 0, 1, 'h004);
    e10(4, 2, 0, 1, 1, 'h000);
    e10(3, 2, 0, 0, 1, 'h000);
    pulse10(10'h004);
    step(20);

    // Call at the current floor: door opens at once, no motion, nothing pending.
    do_reset();
    e10(1, 0, 0, 1, 1, 'h000);
    e10(3, 0, 0, 0, 1, 'h000);
    pulse10(10'h001);
    step(8);

    // Up to 5 with calls at 3 and 1 added at floor 2, then reverse to 1.
    do_reset();
    e10(1, 0, 0, 0, 1, 'h020);
    e10(1, 0, 1, 0, 1, 'h020);
    e10(4, 1, 1, 0, 1, 'h020);
    e10(4, 2, 1, 0, 1, 'h020);
    e10(1, 2, 1, 0, 1, 'h02A);
    e10(3, 3, 0, 1, 1, 'h022);
    e10(3, 3, 0, 0, 1, 'h022);
    e10(1, 3, 1, 0, 1, 'h022);
    e10(4, 4, 1, 0, 1, 'h022);
    e10(4, 5, 0, 1, 1, 'h002);
    e10(3, 5, 0, 0, 1, 'h002);
    e10(1, 5, 1, 0, 0, 'h002);
    e10(4, 4, 1, 0, 0, 'h002);
    e10(4, 3, 1, 0, 0, 'h002);
    e10(4, 2, 1, 0, 0, 'h002);
    e10(4, 1, 0, 1, 0, 'h000);
    e10(3, 1, 0, 0, 0, 'h000);
    pulse10(10'h020);
    step(9);
    pulse10(10'h00A);
    step(45);

    // Door at floor 4 re-pressed on its second dwell cycle extends the dwell.
    do_reset();
    e10(1, 0, 0, 0, 1, 'h010);
    e10(1, 0, 1, 0, 1, 'h010);
    for (int f = 1; f <= 3; f++) e10(4, f, 1, 0, 1, 'h010);
    e10(4, 4, 0, 1, 1, 'h000);
    e10(5, 4, 0, 0, 1, 'h000);
    pulse10(10'h010);
    step(18);
    pulse10(10'h010);
    step(10);

    // Reset while travelling between floors 2 and 3 toward 7: no call survives.
    do_reset();
    e10(1, 0, 0, 0, 1, 'h080);
    e10(1, 0, 1, 0, 1, 'h080);
    e10(4, 1, 1, 0, 1, 'h080);
    e10(4, 2, 1, 0, 1, 'h080);
    pulse10(10'h080);
    step(10);
    do_reset();
    step(12);

    // 16-floor build: to the top floor without wrapping, then all the way down.
    do_reset();
    e16(1, 0, 0, 0, 1, 'h8000);
    e16(1, 0, 1, 0, 1, 'h8000);
    for (int f = 1; f <= 14; f++) e16(4, f, 1, 0, 1, 'h8000);
    e16(4, 15, 0, 1, 1, 'h0000);
    e16(3, 15, 0, 0, 1, 'h0000);
    e16(1, 15, 0, 0, 1, 'h0001);
    e16(1, 15, 1, 0, 0, 'h0001);
    for (int f = 14; f >= 1; f--) e16(4, f, 1, 0, 0, 'h0001);
    e16(4, 0, 0, 1, 0, 'h0000);
    e16(3, 0, 0, 0, 0, 'h0000);
    pulse16(16'h8000);
    step(64);
    pulse16(16'h0001);
    step(70);

    // Give stragglers a bounded window, then every expected change must be seen.
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) step(1);
    check("u10 expected changes left", q0.size(), 0);
    check("u16 expected changes left", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
